// File: rtl/isa_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : isa_pkg
// Description : ISA-wide constants shared by fetch, decode and hazard logic,
//               plus the fetch-stage FSM and output-source encodings.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package isa_pkg;

  localparam int ISA_ADDR_W  = 12;
  localparam int ISA_INSTR_W = 19;

  localparam logic [ISA_INSTR_W-1:0] ISA_HALT_WORD = '1;
  localparam logic [ISA_INSTR_W-1:0] ISA_NOP_WORD  = '0;

  // Fetch FSM: sweep-clear after reset, then normal operation.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fetch_state_e;

  // Which registered source currently drives the instruction output.
  typedef enum logic [1:0] {
    SRC_NOP  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_HALT = 2'd2
  } out_src_e;

endpackage
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : instr_mem_array
// Description : DEPTH x DW synchronous RAM, one write port, one registered
//               read port, read-first on address collision. No array reset.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module instr_mem_array #(
  parameter int AW    = 12,
  parameter int DW    = 19,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Write port; the array is initialised by the parent's clear sweep.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; sampling the old contents gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : instr_fetch_mem
// Description : Loadable instruction memory for the fetch stage. Sweeps the
//               array to HALT after reset, then serves one-cycle registered
//               fetches with stall/flush control, range checking and a
//               sticky halt flag.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module instr_fetch_mem
  import isa_pkg::*;
#(
  parameter int                 ADDR_W    = ISA_ADDR_W,
  parameter int                 INSTR_W   = ISA_INSTR_W,
  parameter int                 DEPTH     = 4096,
  parameter logic [INSTR_W-1:0] HALT_WORD = '1,
  parameter logic [INSTR_W-1:0] NOP_WORD  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ld_en,
  input  logic [ADDR_W-1:0]  i_ld_addr,
  input  logic [INSTR_W-1:0] i_ld_data,
  output logic               o_ld_err,
  output logic               o_ready,
  input  logic [ADDR_W-1:0]  i_pc_in,
  input  logic               i_rd_en,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic [INSTR_W-1:0] o_ins_out,
  output logic               o_ins_valid,
  output logic               o_oor,
  output logic               o_halted
);

  // Array index width; a single-word array still needs one address bit.
  localparam int                MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
  localparam logic [MEM_AW-1:0] c_last  = MEM_AW'(DEPTH - 1);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [MEM_AW-1:0]  r_clr_ptr;

  out_src_e           r_src;
  logic               r_valid;
  logic               r_oor;
  logic               r_halted;
  logic               r_fresh;
  logic               r_ready;
  logic               r_ld_err;

  logic               w_ld_in_range;
  logic               w_pc_in_range;
  logic               w_ld_ok;
  logic               w_ld_rej;
  logic               w_we;
  logic [MEM_AW-1:0]  w_waddr;
  logic [INSTR_W-1:0] w_wdata;
  logic               w_re;
  logic [INSTR_W-1:0] w_rdata;
  logic               w_halted;

  assign w_ld_in_range = ({1'b0, i_ld_addr} < c_depth);
  assign w_pc_in_range = ({1'b0, i_pc_in} < c_depth);

  // Only an unstalled, unflushed in-range fetch in RUN touches the array.
  assign w_re = (r_state == RUN) && !i_flush && !i_stall && i_rd_en && w_pc_in_range;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and write-port steering: clear sweep owns the port in CLEAR.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = i_ld_addr[MEM_AW-1:0];
    w_wdata     = i_ld_data;
    w_ld_ok     = 1'b0;
    w_ld_rej    = 1'b0;
    case (r_state)
      CLEAR: begin
        w_we     = !rst;
        w_waddr  = r_clr_ptr;
        w_wdata  = HALT_WORD;
        w_ld_rej = i_ld_en;
        if (r_clr_ptr == c_last) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_ld_ok  = i_ld_en && w_ld_in_range;
        w_ld_rej = i_ld_en && !w_ld_in_range;
        w_we     = w_ld_ok && !rst;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Clear-sweep pointer advances once per CLEAR cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_ptr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_ptr <= r_clr_ptr + MEM_AW'(1);
    end
  end

  instr_mem_array #(
    .AW    (MEM_AW),
    .DW    (INSTR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (i_pc_in[MEM_AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Output control: flush beats stall beats fetch; status flags alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src    <= SRC_NOP;
      r_valid  <= 1'b0;
      r_oor    <= 1'b0;
      r_halted <= 1'b0;
      r_fresh  <= 1'b0;
      r_ready  <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= w_ld_rej;
      r_ready  <= (w_state_nxt == RUN);
      r_halted <= w_ld_ok ? 1'b0 : w_halted;
      r_fresh  <= 1'b0;
      if (r_state == RUN) begin
        if (i_flush) begin
          r_src   <= SRC_NOP;
          r_valid <= 1'b0;
          r_oor   <= 1'b0;
        end else if (!i_stall) begin
          if (i_rd_en) begin
            r_valid <= 1'b1;
            r_fresh <= 1'b1;
            if (w_pc_in_range) begin
              r_src <= SRC_MEM;
              r_oor <= 1'b0;
            end else begin
              r_src <= SRC_HALT;
              r_oor <= 1'b1;
            end
          end else begin
            r_valid <= 1'b0;
          end
        end
      end
    end
  end

  // Output mux over registered sources; unread array data holds its value.
  always_comb begin
    case (r_src)
      SRC_MEM:  o_ins_out = w_rdata;
      SRC_HALT: o_ins_out = HALT_WORD;
      default:  o_ins_out = NOP_WORD;
    endcase
  end

  // The array word is only known after the fetch edge, so a freshly
  // delivered HALT raises the flag directly and is latched one edge later.
  assign w_halted = r_halted || (r_fresh && r_valid && (o_ins_out == HALT_WORD));

  assign o_ins_valid = r_valid;
  assign o_oor       = r_oor;
  assign o_halted    = w_halted;
  assign o_ready     = r_ready;
  assign o_ld_err    = r_ld_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_instr_fetch_mem
// Description : Self-checking bench for instr_fetch_mem with DEPTH=16.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_instr_fetch_mem;

  localparam int          AW    = 12;
  localparam int          DW    = 19;
  localparam int          DEPTH = 16;
  localparam logic [18:0] HALT  = 19'h7FFFF;
  localparam logic [18:0] NOP   = 19'h00000;

  logic          clk;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_err;
  logic          ready;
  logic [AW-1:0] pc_in;
  logic          rd_en;
  logic          stall;
  logic          flush;
  logic [DW-1:0] ins_out;
  logic          ins_valid;
  logic          oor;
  logic          halted;

  instr_fetch_mem #(
    .ADDR_W  (AW),
    .INSTR_W (DW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ld_en     (ld_en),
    .i_ld_addr   (ld_addr),
    .i_ld_data   (ld_data),
    .o_ld_err    (ld_err),
    .o_ready     (ready),
    .i_pc_in     (pc_in),
    .i_rd_en     (rd_en),
    .i_stall     (stall),
    .i_flush     (flush),
    .o_ins_out   (ins_out),
    .o_ins_valid (ins_valid),
    .o_oor       (oor),
    .o_halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] ins;
    logic        vld;
    logic        oor;
    logic        hlt;
    logic        hk;     // halted value is determined by the model
    logic        lderr;
  } exp_t;

  exp_t        sbq[$];
  exp_t        m;
  logic [18:0] m_mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m = '{ins: NOP, vld: 1'b0, oor: 1'b0, hlt: 1'b0, hk: 1'b1, lderr: 1'b0};
    for (int i = 0; i < DEPTH; i++) m_mem[i] = HALT;
  endtask

  // One RUN-mode cycle: drive inputs, push the expected outputs, clock,
  // then pop and compare against the DUT.
  task automatic step(input string tag,
                      input logic ld, input logic [11:0] la, input logic [18:0] ldd,
                      input logic rd, input logic [11:0] pc,
                      input logic st, input logic fl);
    exp_t e;
    logic newhalt;
    logic accepted;
    ld_en = ld; ld_addr = la; ld_data = ldd;
    rd_en = rd; pc_in = pc; stall = st; flush = fl;
    e = m;
    e.lderr = ld && (la >= 12'(DEPTH));
    if (fl) begin
      e.ins = NOP; e.vld = 1'b0; e.oor = 1'b0;
    end else if (!st) begin
      if (rd) begin
        if (pc < 12'(DEPTH)) begin
          e.ins = m_mem[pc[3:0]]; e.oor = 1'b0;
        end else begin
          e.ins = HALT; e.oor = 1'b1;
        end
        e.vld = 1'b1;
      end else begin
        e.vld = 1'b0;
      end
    end
    newhalt  = !fl && !st && rd && (e.ins == HALT);
    accepted = ld && (la < 12'(DEPTH));
    if (accepted) m_mem[la[3:0]] = ldd;
    if (newhalt && accepted) begin
      e.hk = 1'b0;
    end else if (newhalt) begin
      e.hlt = 1'b1; e.hk = 1'b1;
    end else if (accepted) begin
      e.hlt = 1'b0; e.hk = 1'b1;
    end
    sbq.push_back(e);
    m = e;
    tick();
    e = sbq.pop_front();
    check_eq({tag, ".ins"}, 32'(ins_out), 32'(e.ins));
    check_eq({tag, ".vld"}, 32'(ins_valid), 32'(e.vld));
    check_eq({tag, ".oor"}, 32'(oor), 32'(e.oor));
    check_eq({tag, ".lderr"}, 32'(ld_err), 32'(e.lderr));
    if (e.hk) check_eq({tag, ".halted"}, 32'(halted), 32'(e.hlt));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 12'd0, 19'd0, 1'b0, 12'd0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input string tag, input logic [11:0] pc);
    step(tag, 1'b0, 12'd0, 19'd0, 1'b1, pc, 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [11:0] a, input logic [18:0] d);
    step(tag, 1'b1, a, d, 1'b0, 12'd0, 1'b0, 1'b0);
  endtask

  // Sweep after reset release: ready low for DEPTH cycles, high on the next.
  task automatic sweep_check(input string tag, input int ld_cycle);
    check_eq({tag, ".ready0"}, 32'(ready), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      ld_en   = (i == ld_cycle);
      ld_addr = 12'd3;
      ld_data = 19'h00AAA;
      rd_en   = 1'b1;
      pc_in   = 12'd3;
      tick();
      check_eq($sformatf("%s.ready%0d", tag, i), 32'(ready), 32'(i == DEPTH));
      check_eq($sformatf("%s.vld%0d", tag, i), 32'(ins_valid), 32'd0);
      check_eq($sformatf("%s.lderr%0d", tag, i), 32'(ld_err), 32'(i == ld_cycle));
    end
    ld_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    pc_in = '0; rd_en = 1'b0; stall = 1'b0; flush = 1'b0;
    model_reset();
    tick();
    tick();
    check_eq("rst.ins", 32'(ins_out), 32'(NOP));
    check_eq("rst.vld", 32'(ins_valid), 32'd0);
    check_eq("rst.oor", 32'(oor), 32'd0);
    check_eq("rst.halted", 32'(halted), 32'd0);
    check_eq("rst.ready", 32'(ready), 32'd0);
    check_eq("rst.lderr", 32'(ld_err), 32'd0);
    rst = 1'b0;

    // Load attempt during the sweep is rejected and must not land.
    sweep_check("clr", 5);

    for (int a = 0; a < DEPTH; a++) fetch($sformatf("halt%0d", a), 12'(a));

    load("ld1", 12'd1, 19'h0381F);
    load("ld2", 12'd2, 19'h00080);
    fetch("f1", 12'd1);
    fetch("f2", 12'd2);
    idle("idle0");

    fetch("oor20", 12'd20);
    idle("oor_hold");
    load("ld5", 12'd5, 19'h00123);
    fetch("f5", 12'd5);

    fetch("st_f1", 12'd1);
    step("st1", 1'b0, 12'd0, 19'd0, 1'b1, 12'd2, 1'b1, 1'b0);
    step("st2", 1'b0, 12'd0, 19'd0, 1'b1, 12'd5, 1'b1, 1'b0);
    step("st3", 1'b0, 12'd0, 19'd0, 1'b1, 12'd20, 1'b1, 1'b0);
    step("stfl", 1'b0, 12'd0, 19'd0, 1'b1, 12'd2, 1'b1, 1'b1);
    idle("fl_hold");
    step("fl_rd", 1'b0, 12'd0, 19'd0, 1'b1, 12'd1, 1'b0, 1'b1);

    load("ld16", 12'd16, 19'h00055);
    idle("ld16_after");
    fetch("f0_chk", 12'd0);
    fetch("f3_chk", 12'd3);

    // Collision: load and fetch address 3 together.
    step("rdw", 1'b1, 12'd3, 19'h12345, 1'b1, 12'd3, 1'b0, 1'b0);
    fetch("rdw_new", 12'd3);
    fetch("f1_again", 12'd1);

    // Reset mid-RUN: sweep restarts and loaded contents are gone.
    rst = 1'b1;
    tick();
    check_eq("rrst.ready", 32'(ready), 32'd0);
    check_eq("rrst.vld", 32'(ins_valid), 32'd0);
    check_eq("rrst.halted", 32'(halted), 32'd0);
    rst = 1'b0;
    model_reset();
    sweep_check("reclr", 0);
    fetch("post_f1", 12'd1);
    fetch("post_f2", 12'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
Parametrised, loadable successor to the fixed combinational instruction ROM. It is a synchronous instruction memory with a program-load write port and a one-cycle registered read, and it sits between the PC register and the IF/ID pipeline register. It clears itself to HALT words after reset and supports pipeline stall and flush. It also flags out-of-range fetches and a sticky halt condition.

Parameters:
ADDR_W, 12, PC and load-address width
INSTR_W, 19, instruction word width
DEPTH, 4096, implemented words; must satisfy DEPTH <= 2**ADDR_W
HALT_WORD, all ones (INSTR_W bits), halt instruction and fill value
NOP_WORD, 0 (INSTR_W bits), bubble inserted on flush

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
ld_en  in  1  program-load write strobe
ld_addr  in  ADDR_W  load address
ld_data  in  INSTR_W  load data
ld_err  out  1  one-cycle pulse when a load is rejected
ready  out  1  high once the clear sweep has finished
pc_in  in  ADDR_W  fetch address
rd_en  in  1  fetch request
stall  in  1  hold the current output
flush  in  1  replace the next output with a bubble
ins_out  out  INSTR_W  fetched instruction (registered)
ins_valid  out  1  ins_out is a real fetch
oor  out  1  the registered fetch was out of range
halted  out  1  sticky; set when a valid HALT_WORD is delivered

Behaviour:
- Reset values: rst=1 sets the FSM to CLEAR with clr_ptr=0. It also sets ins_out=NOP_WORD, ins_valid=0, oor=0, halted=0, ready=0 and ld_err=0.
- CLEAR state:
  - Writes HALT_WORD to address clr_ptr each cycle and increments clr_ptr.
  - After writing DEPTH-1, it moves to RUN and sets ready=1 on the next cycle.
  - The sweep therefore takes exactly DEPTH cycles.
- Any ld_en=1 during CLEAR is dropped and pulses ld_err for one cycle. rd_en is ignored during CLEAR, and ins_valid stays 0.
- RUN state loads:
  - ld_en with ld_addr < DEPTH writes ld_data at the clock edge.
  - ld_en with ld_addr >= DEPTH is dropped and pulses ld_err.
  - Any accepted load clears halted.
- RUN state fetch, read latency 1:
  - pc_in and rd_en are sampled at edge N, and ins_out/ins_valid update at edge N.
  - The result is visible in cycle N+1.
- Priority each RUN cycle is rst > flush > stall > rd_en:
  - flush: ins_out=NOP_WORD, ins_valid=0, oor=0. This applies even if stall is also high.
  - stall (without flush): ins_out, ins_valid and oor hold their values. No new read occurs.
  - rd_en with pc_in < DEPTH: ins_out=mem[pc_in], ins_valid=1, oor=0.
  - rd_en with pc_in >= DEPTH: ins_out=HALT_WORD, ins_valid=1, oor=1.
  - rd_en=0: ins_valid=0 and ins_out holds its value.
- Read-during-write to the same address in the same cycle is read-first: the old word is returned.
- halted is set at the edge where the new ins_valid=1 and the new ins_out==HALT_WORD. It stays high until rst or an accepted load.
- Fetching continues while halted; stopping the PC is the controller's job.
- rst during CLEAR restarts the sweep from 0.
- rst during RUN re-enters CLEAR, and previously loaded contents are lost.
- FSM states: CLEAR -> RUN only. There are no other transitions except rst back to CLEAR.

Decomposition:
- Shared package isa_pkg holds INSTR_W, ADDR_W, HALT_WORD and NOP_WORD, so the decoder and hazard unit use the same values. It also holds the fetch FSM state enum {CLEAR, RUN}.
- Sub-module instr_mem_array: a DEPTH x INSTR_W synchronous RAM with one write port and one read port, registered read, read-first. It has no reset on the array; clearing is done by the parent's sweep.
- instr_fetch_mem contains the FSM, the address muxing (clear vs load), range checks and output control.

Test Plan:
- Reset with DEPTH=16 → ready=0 for 16 cycles and rises on cycle 17. Reading addresses 0..15 afterwards returns 19'h7FFFF with ins_valid=1 and halted=1.
- Load 0x0381F at address 1 and 0x0080 at address 2, then fetch pc 1 and pc 2 on consecutive cycles → ins_out is 0x0381F and then 0x0080 with a one-cycle latency and ins_valid=1.
- Fetch pc=20 with DEPTH=16 → ins_out=0x7FFFF, oor=1, halted=1. An accepted load then clears halted to 0.
- Fetch pc 1, then stall for 3 cycles while pc_in changes → ins_out holds 0x0381F. Asserting flush together with stall gives ins_out=0, ins_valid=0.
- ld_en during CLEAR, and ld_addr=16 with DEPTH=16 in RUN → each gives a one-cycle ld_err pulse and memory is unchanged.
- Same-cycle load of 0x12345 and fetch at address 3 (old value 0x7FFFF) → the fetch returns 0x7FFFF, and the next fetch of address 3 returns 0x12345. Asserting rst mid-RUN restarts the sweep with ready=0.
